// File: rtl/pipe_ctrl.sv
// pipe_ctrl: turns execute-stage jump/hold into PC redirect, stall and flush controls,
// arbitrating freeze with an external bus hold. Define PIPE_CTRL_WDT_EN for the watchdog.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned HOLD_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_hold_i,
    input  logic        bus_hold_req_i,
    output logic        bus_hold_gnt_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        timeout_o,
    output logic        busy_o
);

    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam bit               MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4 || HOLD_TIMEOUT < 2 || HOLD_TIMEOUT > 255) begin : g_param_check
        $error("pipe_ctrl: FLUSH_CYCLES or HOLD_TIMEOUT out of range");
    end

`ifdef PIPE_CTRL_WDT_EN
    typedef enum logic [1:0] {RUN, FLUSH, BUSHOLD, LOCKOUT} state_t;
    localparam logic [CNT_W-1:0] HT_LAST = CNT_W'(HOLD_TIMEOUT - 1);
    logic [CNT_W-1:0] wdt_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;
    logic             timeout_q;
`else
    typedef enum logic [1:0] {RUN, FLUSH, BUSHOLD} state_t;
`endif

    state_t           state;
    logic             pend_vld;
    logic [31:0]      pend_addr;
    logic [CNT_W-1:0] flush_cnt;

    logic             frozen;
    logic             issue;
    logic [31:0]      issue_addr;
    logic             flush_act;
    logic             hold_act;

    // A fresh jump always beats a buffered one; a buffered jump replays as soon as the freeze lifts.
    always_comb begin
        frozen     = (state == BUSHOLD) && bus_hold_req_i;
        issue      = !frozen && (jump_en_i || pend_vld);
        issue_addr = jump_en_i ? jump_addr_i : pend_addr;
        flush_act  = issue || (state == FLUSH);
`ifdef PIPE_CTRL_WDT_EN
        if (state == LOCKOUT && flush_cnt != '0)
            flush_act = 1'b1;
        lock_cnt_nxt = '0;
        if (issue)
            lock_cnt_nxt = FLUSH_RELOAD;
        else if (flush_cnt != '0)
            lock_cnt_nxt = flush_cnt - CNT_ONE;
`endif
        hold_act   = frozen || (ex_hold_i && !issue);
    end

    assign bus_hold_gnt_o = frozen;
    assign jump_en_o      = issue;
    assign jump_addr_o    = issue ? issue_addr : 32'h0;
    assign hold_pc_o      = hold_act;
    assign hold_if_id_o   = hold_act;
    assign hold_id_ex_o   = hold_act;
    assign flush_if_id_o  = flush_act;
    assign flush_id_ex_o  = flush_act;
    assign busy_o         = (state != RUN) || pend_vld;
`ifdef PIPE_CTRL_WDT_EN
    assign timeout_o      = timeout_q;
`else
    assign timeout_o      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            flush_cnt <= '0;
`ifdef PIPE_CTRL_WDT_EN
            wdt_cnt   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            if (issue)
                pend_vld <= 1'b0;
`ifdef PIPE_CTRL_WDT_EN
            timeout_q <= 1'b0;
            if (state != BUSHOLD)
                wdt_cnt <= '0;
`endif
            case (state)
                RUN: begin
                    if (issue && MULTI_FLUSH) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (bus_hold_req_i) begin
                        state <= BUSHOLD;
                    end
                end
                // flush_cnt counts remaining flush cycles including the current one
                FLUSH: begin
                    if (issue) begin
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (flush_cnt == CNT_ONE) begin
                        flush_cnt <= '0;
                        state     <= bus_hold_req_i ? BUSHOLD : RUN;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_ONE;
                    end
                end
                BUSHOLD: begin
                    if (!bus_hold_req_i) begin
                        if (issue && MULTI_FLUSH) begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_RELOAD;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        if (jump_en_i) begin
                            pend_vld  <= 1'b1;
                            pend_addr <= jump_addr_i;
                        end
`ifdef PIPE_CTRL_WDT_EN
                        if (wdt_cnt == HT_LAST) begin
                            state     <= LOCKOUT;
                            timeout_q <= 1'b1;
                        end else begin
                            wdt_cnt <= wdt_cnt + CNT_ONE;
                        end
`endif
                    end
                end
`ifdef PIPE_CTRL_WDT_EN
                // Bus request must be seen low once before it can be granted again.
                LOCKOUT: begin
                    flush_cnt <= lock_cnt_nxt;
                    if (!bus_hold_req_i)
                        state <= (lock_cnt_nxt != '0) ? FLUSH : RUN;
                end
`endif
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (FLUSH_CYCLES=3, HOLD_TIMEOUT=4).
// Signal vector order: {jump_en, flush_if_id, flush_id_ex, hold_pc, hold_if_id, hold_id_ex, gnt, timeout, busy}.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        ex_hold_i = 1'b0;
    logic        bus_hold_req_i = 1'b0;
    logic        bus_hold_gnt_o, jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o, timeout_o, busy_o;
    logic [31:0] jump_addr_o;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.FLUSH_CYCLES(3), .HOLD_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_hold_i(ex_hold_i), .bus_hold_req_i(bus_hold_req_i),
        .bus_hold_gnt_o(bus_hold_gnt_o),
        .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
        .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .timeout_o(timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] sig();
        return {jump_en_o, flush_if_id_o, flush_id_ex_o, hold_pc_o, hold_if_id_o,
                hold_id_ex_o, bus_hold_gnt_o, timeout_o, busy_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (sig() !== 9'b0 || jump_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_in sig got %b addr %h expected 000000000 addr 0", sig(), jump_addr_o);
        end
        step();
        step();
        rst_n = 1'b1;
        #2;
        checks++;
        if (sig() !== 9'b0 || jump_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_out sig got %b addr %h expected 000000000 addr 0", sig(), jump_addr_o);
        end
        step();
    endtask

    // stim bits: {jump_en_i, ex_hold_i, bus_hold_req_i}
    task automatic test_jump_run();
        logic [2:0]  stim [4] = '{3'b100, 3'b000, 3'b000, 3'b000};
        logic [31:0] addr [4] = '{32'h100, 32'h0, 32'h0, 32'h0};
        logic [8:0]  exp  [4] = '{9'b111000000, 9'b011000001, 9'b011000001, 9'b000000000};
        logic [31:0] eadr [4] = '{32'h100, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            {jump_en_i, ex_hold_i, bus_hold_req_i} = stim[i];
            jump_addr_i = addr[i];
            #2;
            checks += 2;
            if (sig() !== exp[i]) begin
                failures++;
                $display("FAIL jump_run[%0d] sig got %b expected %b", i, sig(), exp[i]);
            end
            if (jump_addr_o !== eadr[i]) begin
                failures++;
                $display("FAIL jump_run[%0d] addr got %h expected %h", i, jump_addr_o, eadr[i]);
            end
            step();
        end
    endtask

    task automatic test_ex_hold();
        logic [2:0]  stim [9] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b110, 3'b000, 3'b000, 3'b000};
        logic [31:0] addr [9] = '{32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h180, 32'h0, 32'h0, 32'h0};
        logic [8:0]  exp  [9] = '{9'b000111000, 9'b000111000, 9'b000111000, 9'b000111000, 9'b000111000,
                                  9'b111000000, 9'b011000001, 9'b011000001, 9'b000000000};
        logic [31:0] eadr [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h180, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            {jump_en_i, ex_hold_i, bus_hold_req_i} = stim[i];
            jump_addr_i = addr[i];
            #2;
            checks += 2;
            if (sig() !== exp[i]) begin
                failures++;
                $display("FAIL ex_hold[%0d] sig got %b expected %b", i, sig(), exp[i]);
            end
            if (jump_addr_o !== eadr[i]) begin
                failures++;
                $display("FAIL ex_hold[%0d] addr got %h expected %h", i, jump_addr_o, eadr[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  stim [5] = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
        logic [31:0] addr [5] = '{32'h900, 32'hA00, 32'h0, 32'h0, 32'h0};
        logic [8:0]  exp  [5] = '{9'b111000000, 9'b111000001, 9'b011000001, 9'b011000001, 9'b000000000};
        logic [31:0] eadr [5] = '{32'h900, 32'hA00, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            {jump_en_i, ex_hold_i, bus_hold_req_i} = stim[i];
            jump_addr_i = addr[i];
            #2;
            checks += 2;
            if (sig() !== exp[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d] sig got %b expected %b", i, sig(), exp[i]);
            end
            if (jump_addr_o !== eadr[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d] addr got %h expected %h", i, jump_addr_o, eadr[i]);
            end
            step();
        end
    endtask

    task automatic test_bus_hold();
        logic [2:0]  stim [8] = '{3'b001, 3'b001, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [31:0] addr [8] = '{32'h0, 32'h0, 32'h200, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [8:0]  exp  [8] = '{9'b000000000, 9'b000111101, 9'b000111101, 9'b000111101,
                                  9'b111000001, 9'b011000001, 9'b011000001, 9'b000000000};
        logic [31:0] eadr [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h300, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            {jump_en_i, ex_hold_i, bus_hold_req_i} = stim[i];
            jump_addr_i = addr[i];
            #2;
            checks += 2;
            if (sig() !== exp[i]) begin
                failures++;
                $display("FAIL bus_hold[%0d] sig got %b expected %b", i, sig(), exp[i]);
            end
            if (jump_addr_o !== eadr[i]) begin
                failures++;
                $display("FAIL bus_hold[%0d] addr got %h expected %h", i, jump_addr_o, eadr[i]);
            end
            step();
        end
    endtask

    task automatic test_release_collision();
        logic [2:0]  stim [7] = '{3'b001, 3'b001, 3'b101, 3'b100, 3'b000, 3'b000, 3'b000};
        logic [31:0] addr [7] = '{32'h0, 32'h0, 32'h400, 32'h500, 32'h0, 32'h0, 32'h0};
        logic [8:0]  exp  [7] = '{9'b000000000, 9'b000111101, 9'b000111101, 9'b111000001,
                                  9'b011000001, 9'b011000001, 9'b000000000};
        logic [31:0] eadr [7] = '{32'h0, 32'h0, 32'h0, 32'h500, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            {jump_en_i, ex_hold_i, bus_hold_req_i} = stim[i];
            jump_addr_i = addr[i];
            #2;
            checks += 2;
            if (sig() !== exp[i]) begin
                failures++;
                $display("FAIL collision[%0d] sig got %b expected %b", i, sig(), exp[i]);
            end
            if (jump_addr_o !== eadr[i]) begin
                failures++;
                $display("FAIL collision[%0d] addr got %h expected %h", i, jump_addr_o, eadr[i]);
            end
            step();
        end
    endtask

    task automatic test_flush_then_grant();
        logic [2:0]  stim [6] = '{3'b101, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        logic [31:0] addr [6] = '{32'hB00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [8:0]  exp  [6] = '{9'b111000000, 9'b011000001, 9'b011000001, 9'b000111101,
                                  9'b000000001, 9'b000000000};
        logic [31:0] eadr [6] = '{32'hB00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            {jump_en_i, ex_hold_i, bus_hold_req_i} = stim[i];
            jump_addr_i = addr[i];
            #2;
            checks += 2;
            if (sig() !== exp[i]) begin
                failures++;
                $display("FAIL flush_grant[%0d] sig got %b expected %b", i, sig(), exp[i]);
            end
            if (jump_addr_o !== eadr[i]) begin
                failures++;
                $display("FAIL flush_grant[%0d] addr got %h expected %h", i, jump_addr_o, eadr[i]);
            end
            step();
        end
    endtask

`ifdef PIPE_CTRL_WDT_EN
    task automatic test_watchdog();
        logic [2:0]  stim [14] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b101, 3'b001, 3'b001,
                                   3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
        logic [31:0] addr [14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h600, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [8:0]  exp  [14] = '{9'b000000000, 9'b000111101, 9'b000111101, 9'b000111101,
                                   9'b000111101, 9'b111000011, 9'b011000001, 9'b011000001,
                                   9'b000000001, 9'b000000001, 9'b000000000, 9'b000111101,
                                   9'b000000001, 9'b000000000};
        logic [31:0] eadr [14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h600, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 14; i++) begin
            {jump_en_i, ex_hold_i, bus_hold_req_i} = stim[i];
            jump_addr_i = addr[i];
            #2;
            checks += 2;
            if (sig() !== exp[i]) begin
                failures++;
                $display("FAIL watchdog[%0d] sig got %b expected %b", i, sig(), exp[i]);
            end
            if (jump_addr_o !== eadr[i]) begin
                failures++;
                $display("FAIL watchdog[%0d] addr got %h expected %h", i, jump_addr_o, eadr[i]);
            end
            step();
        end
    endtask
`else
    task automatic test_watchdog();
        for (int i = 0; i < 13; i++) begin
            logic [8:0] e;
            bus_hold_req_i = (i < 11);
            e = (i == 0 || i == 12) ? 9'b000000000 : (i == 11) ? 9'b000000001 : 9'b000111101;
            #2;
            checks++;
            if (sig() !== e) begin
                failures++;
                $display("FAIL hold_forever[%0d] sig got %b expected %b", i, sig(), e);
            end
            step();
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [8:0] e [5] = '{9'b000000000, 9'b000111101, 9'b000111101, 9'b000111101, 9'b000000000};
        for (int i = 0; i < 4; i++) begin
            bus_hold_req_i = 1'b1;
            jump_en_i      = (i == 2);
            jump_addr_i    = (i == 2) ? 32'h700 : 32'h0;
            #2;
            checks++;
            if (sig() !== e[i]) begin
                failures++;
                $display("FAIL rst_bushold[%0d] sig got %b expected %b", i, sig(), e[i]);
            end
            if (i < 3) step();
        end
        rst_n = 1'b0;
        bus_hold_req_i = 1'b0;
        jump_en_i = 1'b0;
        #1;
        checks++;
        if (sig() !== 9'b0 || jump_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_bushold_async sig got %b addr %h expected 0", sig(), jump_addr_o);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (sig() !== 9'b0 || jump_addr_o !== 32'h0) begin
                failures++;
                $display("FAIL rst_no_replay[%0d] sig got %b addr %h expected 0", i, sig(), jump_addr_o);
            end
            step();
        end
        jump_en_i = 1'b1;
        jump_addr_i = 32'h800;
        #2;
        checks++;
        if (sig() !== 9'b111000000 || jump_addr_o !== 32'h800) begin
            failures++;
            $display("FAIL rst_flush_issue sig got %b addr %h expected 111000000 addr 800", sig(), jump_addr_o);
        end
        step();
        jump_en_i = 1'b0;
        jump_addr_i = 32'h0;
        #2;
        checks++;
        if (sig() !== 9'b011000001) begin
            failures++;
            $display("FAIL rst_flush_state sig got %b expected 011000001", sig());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sig() !== 9'b0) begin
            failures++;
            $display("FAIL rst_flush_async sig got %b expected 000000000", sig());
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (sig() !== 9'b0) begin
                failures++;
                $display("FAIL rst_no_stale_flush[%0d] sig got %b expected 000000000", i, sig());
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_jump_run();
        test_ex_hold();
        test_back_to_back();
        test_bus_hold();
        test_release_collision();
        test_flush_then_grant();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller between the execute stage and the front end (PC register, if_id, id_ex). It turns the execute stage's jump request and hold flag into PC redirect, stall and multi-cycle flush controls. It arbitrates pipeline freeze between the execute stage and an external bus/debug hold requester. Jumps resolved while the pipeline is frozen are buffered and replayed on release.

Parameters:
FLUSH_CYCLES, 1, cycles flush_* stays high per issued jump, counting the issue cycle; legal 1..4
HOLD_TIMEOUT, 64, maximum consecutive cycles of granted bus hold before forced release; legal 2..255
CNT_W, 8, width of the flush and watchdog counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
jump_en_i  in  1  execute stage jump/branch-taken request
jump_addr_i  in  32  execute stage jump target
ex_hold_i  in  1  execute stage hold flag (multi-cycle op in progress)
bus_hold_req_i  in  1  external freeze request, level
bus_hold_gnt_o  out  1  external freeze granted
jump_en_o  out  1  PC redirect strobe
jump_addr_o  out  32  PC redirect target
hold_pc_o  out  1  freeze PC
hold_if_id_o  out  1  freeze if_id
hold_id_ex_o  out  1  freeze id_ex
flush_if_id_o  out  1  clear if_id to NOP
flush_id_ex_o  out  1  clear id_ex to NOP
timeout_o  out  1  one-cycle pulse on forced bus hold release
busy_o  out  1  high while in a non-RUN state or a pending jump is held

Behaviour:
- FSM states: RUN, FLUSH, BUSHOLD, LOCKOUT. Reset state is RUN.
- Registers: pend_vld, pend_addr, flush_cnt, wdt_cnt.
- Reset values: all registered state is 0. All outputs are 0 in RUN when every input is 0.
- RUN, no bus request:
  - jump_en_i=1 -> same cycle (combinational) jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=flush_id_ex_o=1.
  - If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1.
- jump_en_i has priority over ex_hold_i in the same cycle: hold_* stays 0 and the jump is issued.
- ex_hold_i=1 with no jump -> hold_pc_o=hold_if_id_o=hold_id_ex_o=1, same cycle, combinational. No state change.
- FLUSH:
  - flush_* stays 1 each cycle; flush_cnt decrements; go to RUN when flush_cnt reaches 1.
  - A new jump_en_i in FLUSH is issued immediately and reloads flush_cnt=FLUSH_CYCLES-1.
- Bus request grant:
  - bus_hold_req_i=1 in RUN, or in FLUSH after the flush completes -> next cycle bus_hold_gnt_o=1, state BUSHOLD.
  - In BUSHOLD all three hold_* are 1 and wdt_cnt increments from 0.
  - The request-to-grant latency is exactly 1 cycle. The grant is never given mid-flush.
- Jump arriving in BUSHOLD:
  - jump_en_i=1 -> pend_vld<=1, pend_addr<=jump_addr_i. jump_en_o stays 0.
  - A later jump overwrites pend_addr (last wins).
- Bus release:
  - bus_hold_req_i=0 in BUSHOLD -> bus_hold_gnt_o drops the same cycle and the state returns to RUN.
  - If pend_vld, that cycle issues jump_en_o=1 with jump_addr_o=pend_addr, asserts flush_*, clears pend_vld, and enters FLUSH if FLUSH_CYCLES>1.
  - A simultaneous fresh jump_en_i in the release cycle takes priority over pend_addr, and pend_vld is cleared.
- Watchdog (feature enabled):
  - wdt_cnt==HOLD_TIMEOUT-1 while still requested -> timeout_o=1 for one cycle, grant drops, pending jump replayed as on release, state LOCKOUT.
  - LOCKOUT ignores bus_hold_req_i (no grant) until it is seen low for 1 cycle, then goes to RUN.
  - ex_hold_i and jumps behave as in RUN while in LOCKOUT.
- busy_o = (state!=RUN) | pend_vld.
- Asynchronous reset mid-operation discards any pending jump and flush count; outputs return to their reset values immediately.

Optional Feature:
PIPE_CTRL_WDT_EN:
- Defined: watchdog, timeout_o and the LOCKOUT state exist as described.
- Undefined: no wdt_cnt and no LOCKOUT state; bus hold is held indefinitely while requested; timeout_o tied 0.

Test Plan:
- Jump in RUN, FLUSH_CYCLES=3: jump_en_i=1, addr 0x0000_0100 for 1 cycle -> jump_en_o=1 with 0x100 the same cycle; flush_* high for exactly 3 cycles; busy_o high for 2 cycles.
- ex_hold_i high for 5 cycles, jump_en_i low -> hold_* high for exactly those 5 cycles, no flush; then ex_hold_i=1 and jump_en_i=1 together -> jump issued, hold_* low.
- Bus hold with buffered jump: req at cycle 0 -> gnt at cycle 1; jumps 0x200 (cycle 3) and 0x300 (cycle 5) -> no jump_en_o; req low at cycle 8 -> jump_en_o=1 with 0x300 at cycle 8, pend_vld cleared.
- Release collision: pend_addr=0x400 and jump_en_i=1 with 0x500 in the release cycle -> jump_addr_o=0x500; no second jump issued afterwards.
- Watchdog, HOLD_TIMEOUT=4, macro defined: req held high -> gnt for 4 cycles, then timeout_o pulses once and gnt=0; req held 3 more cycles -> no regrant; req low 1 cycle then high -> gnt 1 cycle later.
- Reset mid-flush: rst_n low during FLUSH with pend_vld=1 -> all outputs 0 immediately; after release, no stale jump_en_o or flush.
